// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit that sits beside the main ALU in EX.
// Radix-2 shift-add multiply and restoring divide, one result bit per cycle.
module alu_muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       ALUOp,
   input  logic [6:0]       Funct7,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             is_muldiv,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt, mul_nxt, div_nxt, prod_fix;
   logic [WIDTH-1:0]   opnd, a_mag, b_mag, fast_val, fin_val, quo, rem, quo_fix, rem_fix;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2:0]         op;
   logic               neg, neg_new, a_sgn, b_sgn, a_neg, b_neg;
   logic               is_div, accept, fast, last;

   assign is_muldiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
   assign accept    = (state == IDLE) && start && is_muldiv && !flush;
   assign is_div    = Funct3[2];
   assign last      = (cnt == CNT_W'(1));

   // MULHU, DIVU, REMU are fully unsigned; MULHSU only treats srcA as signed.
   assign a_sgn   = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
   assign b_sgn   = a_sgn && (Funct3 != 3'b010);
   assign a_neg   = a_sgn && srcA[WIDTH-1];
   assign b_neg   = b_sgn && srcB[WIDTH-1];
   assign a_mag   = a_neg ? -srcA : srcA;
   assign b_mag   = b_neg ? -srcB : srcB;
   assign neg_new = (Funct3[2] && Funct3[1]) ? a_neg : (a_neg ^ b_neg);

   always_comb begin
      fast     = 1'b0;
      fast_val = '0;
      if (is_div) begin
         if (srcB == '0) begin
            fast     = 1'b1;
            fast_val = Funct3[1] ? srcA : ALL_ONES;
         end else if (!Funct3[0] && srcA == MIN_NEG && srcB == ALL_ONES) begin
            fast     = 1'b1;
            fast_val = Funct3[1] ? '0 : MIN_NEG;
         end
      end
   end

   // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
   assign mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
   assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
   assign div_nxt   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   assign acc_nxt   = op[2] ? div_nxt : mul_nxt;

   assign prod_fix = neg ? -mul_nxt : mul_nxt;
   assign quo      = div_nxt[WIDTH-1:0];
   assign rem      = div_nxt[2*WIDTH-1:WIDTH];
   assign quo_fix  = neg ? -quo : quo;
   assign rem_fix  = neg ? -rem : rem;

   always_comb begin
      fin_val = '0;
      case (op)
         3'b000:                 fin_val = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fin_val = quo_fix;
         default:                fin_val = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fast ? FIN : CALC;
         CALC:    if (flush) state_nxt = IDLE;
                  else if (last) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The final iteration writes the sign-corrected result so it is valid throughout FIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op     <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         result <= '0;
      end else if (accept) begin
         op   <= Funct3;
         neg  <= neg_new;
         cnt  <= CNT_W'(WIDTH);
         acc  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
         opnd <= is_div ? b_mag : a_mag;
         if (fast) result <= fast_val;
      end else if (state == CALC && !flush) begin
         acc <= acc_nxt;
         cnt <= cnt - CNT_W'(1);
         if (last) result <= fin_val;
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == FIN) && !flush;
   assign stall = ((state == IDLE) && start && is_muldiv) || (state == CALC);

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed-vector bench for alu_muldiv_iter at WIDTH=32.
module tb_alu_muldiv_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, flush;
   logic [1:0]  ALUOp;
   logic [6:0]  Funct7;
   logic [2:0]  Funct3;
   logic [31:0] srcA, srcB;
   logic        is_muldiv, stall, busy, done;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_res = 32'h0;

   alu_muldiv_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct7(Funct7),
      .Funct3(Funct3), .srcA(srcA), .srcB(srcB), .flush(flush),
      .is_muldiv(is_muldiv), .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wait_done(output int cyc, output int stalls);
      cyc = 0;
      stalls = 0;
      while (!done && cyc < 100) begin
         if (stall) stalls++;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; srcA = a; srcB = b; start = 1'b1;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
      int cyc, stalls, pre;
      launch(f3, a, b);
      #1;
      check({tag, "/is_muldiv"}, 32'(is_muldiv), 32'd1);
      pre = stall ? 1 : 0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, stalls);
      if (fast) begin
         check({tag, "/fast_lat"}, 32'(cyc <= 1), 32'd1);
      end else begin
         check({tag, "/lat"}, cyc, 32'd32);
         check({tag, "/stall_cycles"}, pre + stalls, 32'd33);
      end
      check({tag, "/done"}, 32'(done), 32'd1);
      check({tag, "/stall_fin"}, 32'(stall), 32'd0);
      check({tag, "/result"}, result, exp);
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/held"}, result, exp);
      check({tag, "/idle"}, 32'(busy), 32'd0);
      last_res = exp;
   endtask

   initial begin
      int cyc, stalls, n_done;
      reset = 1'b0; start = 1'b0; flush = 1'b0;
      ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000; srcA = '0; srcB = '0;
      #23;
      check("rst/result", result, 32'h0);
      check("rst/done", 32'(done), 32'd0);
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/stall", 32'(stall), 32'd0);
      @(negedge clk); reset = 1'b1;

      // Multiply family
      do_op("mul_neg",    3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      do_op("mulh_min",   3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0);
      do_op("mulhu_max",  3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      do_op("mulhsu_max", 3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      do_op("mul_pos",    3'b000, 32'h12345678,  32'h00000010, 32'h23456780, 1'b0);
      do_op("mulhu_pos",  3'b011, 32'h12345678,  32'h00000010, 32'h00000001, 1'b0);

      // Divide family
      do_op("divu",       3'b101, 32'd100,       32'd7,        32'd14,       1'b0);
      do_op("remu",       3'b111, 32'd100,       32'd7,        32'd2,        1'b0);
      do_op("rem_neg",    3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0);
      do_op("div_neg",    3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0);
      do_op("div_negb",   3'b100, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
      do_op("rem_negb",   3'b110, 32'd100,       32'hFFFFFFF9, 32'd2,        1'b0);
      do_op("divu_max",   3'b101, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 1'b0);

      // Fast paths
      do_op("div_by0",    3'b100, 32'h00001234,  32'h0,        32'hFFFFFFFF, 1'b1);
      do_op("remu_by0",   3'b111, 32'h00001234,  32'h0,        32'h00001234, 1'b1);
      do_op("div_ovf",    3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);
      do_op("rem_ovf",    3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1);

      // Non-M op is ignored
      @(negedge clk);
      ALUOp = 2'b10; Funct7 = 7'h00; Funct3 = 3'b000; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
      #1;
      check("nonm/is_muldiv", 32'(is_muldiv), 32'd0);
      check("nonm/stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      check("nonm/busy", 32'(busy), 32'd0);
      start = 1'b0;

      // flush in IDLE blocks acceptance
      launch(3'b000, 32'd3, 32'd3);
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_idle/busy", 32'(busy), 32'd0);
      start = 1'b0; flush = 1'b0;

      // start while busy is ignored
      launch(3'b101, 32'd100, 32'd7);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      Funct3 = 3'b000; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, stalls);
      check("midstart/done", 32'(done), 32'd1);
      check("midstart/result", result, 32'd14);
      @(posedge clk); #1;
      check("midstart/no_queue", 32'(busy), 32'd0);
      last_res = 32'd14;

      // flush at iteration 10
      launch(3'b000, 32'd5, 32'd5);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check("flush/done_low", 32'(done), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush/busy", 32'(busy), 32'd0);
      check("flush/result", result, last_res);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("flush/no_done", n_done, 32'd0);

      // asynchronous reset mid-CALC
      launch(3'b000, 32'd7, 32'd3);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst/result", result, 32'h0);
      check("arst/busy", 32'(busy), 32'd0);
      check("arst/stall", 32'(stall), 32'd0);
      check("arst/done", 32'(done), 32'd0);
      @(negedge clk); reset = 1'b1;
      do_op("post_rst",   3'b000, 32'd7,         32'd3,        32'd21,       1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
